// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : Double-buffered UART transmitter. A holding register accepts
//                characters from the host while the shift register serialises
//                the previous one. Bit timing comes from a 16x baud enable;
//                frame format (5-8 data bits, optional odd/even parity, one
//                or two stop bits) is latched at the start of each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       brgCLKEN,
    input  logic [1:0] txLEN,
    input  logic       txPARE,
    input  logic       txPARO,
    input  logic       txSTOP,
    input  logic [7:0] txDATA,
    input  logic       txLOAD,
    output logic       txOUT,
    output logic       txEMPTY,
    output logic       txBUSY
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP1  = 3'd4;
    localparam logic [2:0] c_STOP2  = 3'd5;

    logic [2:0] r_state;
    logic [7:0] r_hold;
    logic       r_empty;
    logic [7:0] r_shift;
    logic [1:0] r_len;
    logic       r_pare;
    logic       r_paro;
    logic       r_stop;
    logic [3:0] r_timer;
    logic [2:0] r_bitcnt;
    logic       r_par;
    logic       r_out;

    logic       w_bit_end;
    logic       w_last_data;
    logic       w_par_next;

    // A bit period closes on the 16th baud enable of that bit.
    assign w_bit_end   = brgCLKEN && (r_timer == 4'd15);
    // The last data bit index is character length minus one (len code + 4).
    assign w_last_data = (r_bitcnt == ({1'b0, r_len} + 3'd4));
    // Running parity including the data bit now finishing.
    assign w_par_next  = r_par ^ r_shift[0];

    // Holding register, frame sequencing and the registered serial output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_hold   <= 8'h00;
            r_empty  <= 1'b1;
            r_shift  <= 8'h00;
            r_len    <= 2'd0;
            r_pare   <= 1'b0;
            r_paro   <= 1'b0;
            r_stop   <= 1'b0;
            r_timer  <= 4'd0;
            r_bitcnt <= 3'd0;
            r_par    <= 1'b0;
            r_out    <= 1'b1;
        end else begin
            // Loads are only taken while the holding register is empty.
            if (txLOAD && r_empty) begin
                r_hold  <= txDATA;
                r_empty <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    r_out <= 1'b1;
                    // Start immediately; the bit timer is aligned to this edge.
                    if (!r_empty) begin
                        r_shift  <= r_hold;
                        r_len    <= txLEN;
                        r_pare   <= txPARE;
                        r_paro   <= txPARO;
                        r_stop   <= txSTOP;
                        r_empty  <= 1'b1;
                        r_timer  <= 4'd0;
                        r_bitcnt <= 3'd0;
                        r_par    <= 1'b0;
                        r_state  <= c_START;
                        r_out    <= 1'b0;
                    end
                end
                default: begin
                    if (brgCLKEN) begin
                        r_timer <= r_timer + 4'd1;
                    end
                    if (w_bit_end) begin
                        case (r_state)
                            c_START: begin
                                r_state <= c_DATA;
                                r_out   <= r_shift[0];
                            end
                            c_DATA: begin
                                r_shift <= {1'b0, r_shift[7:1]};
                                r_par   <= w_par_next;
                                if (w_last_data) begin
                                    if (r_pare) begin
                                        r_state <= c_PARITY;
                                        r_out   <= w_par_next ^ r_paro;
                                    end else begin
                                        r_state <= c_STOP1;
                                        r_out   <= 1'b1;
                                    end
                                end else begin
                                    r_bitcnt <= r_bitcnt + 3'd1;
                                    r_out    <= r_shift[1];
                                end
                            end
                            c_PARITY: begin
                                r_state <= c_STOP1;
                                r_out   <= 1'b1;
                            end
                            c_STOP1: begin
                                r_state <= r_stop ? c_STOP2 : c_IDLE;
                                r_out   <= 1'b1;
                            end
                            default: begin
                                // STOP2 and any unused encoding return to idle.
                                r_state <= c_IDLE;
                                r_out   <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign txOUT   = r_out;
    assign txEMPTY = r_empty;
    assign txBUSY  = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Expected line levels are
//                built per frame as a list of bit values from the character
//                format; every clock of every bit is compared.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       brgCLKEN = 1'b0;
    logic [1:0] txLEN = 2'd0;
    logic       txPARE = 1'b0;
    logic       txPARO = 1'b0;
    logic       txSTOP = 1'b0;
    logic [7:0] txDATA = 8'h00;
    logic       txLOAD = 1'b0;
    logic       txOUT;
    logic       txEMPTY;
    logic       txBUSY;

    int   checks = 0;
    int   errors = 0;
    int   period = 1;
    int   phase = 0;
    bit   fired = 1'b0;
    bit   exp_empty = 1'b1;
    bit   exp_bits[$];

    always #5 clk = ~clk;

    uart_tx dut (
        .clk      (clk),
        .rst      (rst),
        .brgCLKEN (brgCLKEN),
        .txLEN    (txLEN),
        .txPARE   (txPARE),
        .txPARO   (txPARO),
        .txSTOP   (txSTOP),
        .txDATA   (txDATA),
        .txLOAD   (txLOAD),
        .txOUT    (txOUT),
        .txEMPTY  (txEMPTY),
        .txBUSY   (txBUSY)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: baud enable every 'period' clocks, inputs applied at negedge.
    task automatic tick();
        brgCLKEN = (phase == period - 1);
        phase = (phase + 1) % period;
        @(posedge clk);
        fired = brgCLKEN;
        @(negedge clk);
    endtask

    // Line levels of a whole frame, one entry per bit period.
    function automatic void build(input logic [7:0] d, input logic [1:0] len,
                                  input logic pare, input logic paro, input logic stop);
        int n;
        logic [7:0] m;
        n = int'(len) + 5;
        m = 8'((1 << n) - 1);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) exp_bits.push_back(d[i]);
        if (pare) exp_bits.push_back(bit'(($countones(d & m) + int'(paro)) % 2));
        exp_bits.push_back(1'b1);
        if (stop) exp_bits.push_back(1'b1);
    endfunction

    task automatic do_load(input logic [7:0] d);
        txDATA = d;
        txLOAD = 1'b1;
        tick();
        txLOAD = 1'b0;
        exp_empty = 1'b0;
    endtask

    // Expects the holding register full and the transmitter idle on entry.
    task automatic frame(input logic [7:0] d, input logic [1:0] len, input logic pare,
                         input logic paro, input logic stop, input int load_at,
                         input logic [7:0] ld, input int ign_at, input int abort_at);
        int cnt;
        int k;
        bit did;
        build(d, len, pare, paro, stop);
        txLEN = len; txPARE = pare; txPARO = paro; txSTOP = stop;
        chk("idle_busy", txBUSY, 8'd0);
        chk("idle_out", txOUT, 8'd1);
        chk("idle_empty", txEMPTY, 8'(exp_empty));
        tick();
        exp_empty = 1'b1;
        txLEN = 2'($urandom); txPARE = 1'($urandom); txPARO = 1'($urandom); txSTOP = 1'($urandom);
        for (int i = 0; i < exp_bits.size(); i++) begin
            cnt = 0;
            k = 0;
            while (cnt < 16) begin
                chk($sformatf("bit%0d_out", i), txOUT, 8'(exp_bits[i]));
                chk("frame_busy", txBUSY, 8'd1);
                chk("frame_empty", txEMPTY, 8'(exp_empty));
                if (i == abort_at && k == 2) begin
                    rst = 1'b1; txLOAD = 1'b1; txDATA = 8'h99;
                    tick();
                    rst = 1'b0; txLOAD = 1'b0;
                    exp_empty = 1'b1;
                    chk("rst_out", txOUT, 8'd1);
                    chk("rst_empty", txEMPTY, 8'd1);
                    chk("rst_busy", txBUSY, 8'd0);
                    return;
                end
                did = 1'b0;
                if (i == load_at && k == 0) begin txDATA = ld; txLOAD = 1'b1; did = 1'b1; end
                if (i == ign_at && k == 0) begin txDATA = 8'h11; txLOAD = 1'b1; did = 1'b1; end
                tick();
                txLOAD = 1'b0;
                if (did) exp_empty = 1'b0;
                if (fired) cnt++;
                k++;
            end
        end
        chk("end_busy", txBUSY, 8'd0);
        chk("end_out", txOUT, 8'd1);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] d2;
        logic [1:0] len;
        logic       pare, paro, stop;

        // Reset state, with a load presented during reset
        rst = 1'b1; txLOAD = 1'b1; txDATA = 8'hE7;
        tick(); tick();
        txLOAD = 1'b0; rst = 1'b0;
        chk("reset_out", txOUT, 8'd1);
        chk("reset_empty", txEMPTY, 8'd1);
        chk("reset_busy", txBUSY, 8'd0);
        tick();
        chk("reset_stays_idle", txBUSY, 8'd0);

        // 8N1 at full enable rate
        period = 1; phase = 0;
        do_load(8'h55);
        frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, -1, 8'h00, -1, -1);

        // 5O2 at quarter rate, upper data bits must not appear
        period = 4; phase = 0;
        do_load(8'h1F);
        frame(8'h1F, 2'd0, 1'b1, 1'b1, 1'b1, -1, 8'h00, -1, -1);

        // Back-to-back frames, plus a load attempt while the holding register is full
        period = 1; phase = 0;
        do_load(8'hA5);
        frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b1, 3, 8'h3C, 5, -1);
        frame(8'h3C, 2'd2, 1'b1, 1'b0, 1'b0, -1, 8'h00, -1, -1);

        // 7E1, configuration scrambled during the frame
        period = 2; phase = 0;
        do_load(8'h07);
        frame(8'h07, 2'd2, 1'b1, 1'b0, 1'b0, -1, 8'h00, -1, -1);

        // Reset during data bit 3 with a pending character
        period = 1; phase = 0;
        do_load(8'hC3);
        frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1, 8'h5A, -1, 4);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_rst_busy", txBUSY, 8'd0);
            chk("post_rst_out", txOUT, 8'd1);
            chk("post_rst_empty", txEMPTY, 8'd1);
        end
        do_load(8'h96);
        frame(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, -1, 8'h00, -1, -1);

        // Randomised frames, some with a queued follow-on character
        for (int r = 0; r < 8; r++) begin
            period = $urandom_range(1, 3); phase = 0;
            d = 8'($urandom); len = 2'($urandom);
            pare = 1'($urandom); paro = 1'($urandom); stop = 1'($urandom);
            d2 = 8'($urandom);
            do_load(d);
            if (r % 2 == 1) begin
                frame(d, len, pare, paro, stop, $urandom_range(1, 5), d2, -1, -1);
                frame(d2, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      -1, 8'h00, -1, -1);
            end else begin
                frame(d, len, pare, paro, stop, -1, 8'h00, -1, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
